// File: rtl/cp0_intr_unit_if.sv
// cp0_intr_unit_if: pipeline/CP0 signal bundle for the interrupt unit.
interface cp0_intr_unit_if;
   logic [5:0]  hw_int;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] pc_in;
   logic        bd_in;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        eret;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;
   logic        in_handler;
   modport master (
      output hw_int, exc_valid, exc_code, pc_in, bd_in, we, addr, wdata, eret,
      input  rdata, req, handler_pc, epc_out, in_handler
   );
   modport slave (
      input  hw_int, exc_valid, exc_code, pc_in, bd_in, we, addr, wdata, eret,
      output rdata, req, handler_pc, epc_out, in_handler
   );
endinterface

// File: rtl/cp0_intr_unit.sv
// cp0_intr_unit: CP0 SR/Cause/EPC/PRId with interrupt/exception entry and eret.
module cp0_intr_unit #(
   parameter logic [31:0] PRID = 32'h0000_2021
) (
   input logic            clk,
   input logic            reset,
   cp0_intr_unit_if.slave bus
);
   typedef enum logic {NORMAL, HANDLER} state_t;
   state_t      r_state, w_state_nx;
   logic [5:0]  r_im, w_im_nx, r_ip;
   logic        r_ie, w_ie_nx, r_bd, w_bd_nx;
   logic [4:0]  r_exc, w_exc_nx;
   logic [31:0] r_epc, w_epc_nx, w_victim;
   logic        w_exl, w_int_req, w_exc_req, w_req, w_sr_we, w_epc_we;
   assign w_exl     = (r_state == HANDLER);
   assign w_int_req = (|(bus.hw_int & r_im)) & r_ie & ~w_exl;
   assign w_exc_req = bus.exc_valid & ~w_exl;
   assign w_req     = w_int_req | w_exc_req;
   assign w_sr_we   = bus.we & (bus.addr == 5'd12);
   assign w_epc_we  = bus.we & (bus.addr == 5'd14);
   assign w_victim  = bus.bd_in ? bus.pc_in - 32'd4 : bus.pc_in;
   always_comb begin
      w_state_nx = r_state;
      w_im_nx    = r_im;
      w_ie_nx    = r_ie;
      w_bd_nx    = r_bd;
      w_exc_nx   = r_exc;
      w_epc_nx   = r_epc;
      if (w_req) begin
         w_state_nx = HANDLER;
         w_bd_nx    = bus.bd_in;
         w_exc_nx   = w_int_req ? 5'd0 : bus.exc_code;
         w_epc_nx   = {w_victim[31:2], 2'b00};
      end else begin
         if (w_sr_we) begin
            w_im_nx    = bus.wdata[15:10];
            w_ie_nx    = bus.wdata[0];
            w_state_nx = bus.wdata[1] ? HANDLER : NORMAL;
         end
         // eret wins over the EXL bit of a same-cycle SR write
         if (bus.eret && w_exl) w_state_nx = NORMAL;
         if (w_epc_we) w_epc_nx = {bus.wdata[31:2], 2'b00};
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= NORMAL;
         r_im    <= '0;
         r_ie    <= 1'b0;
         r_bd    <= 1'b0;
         r_exc   <= '0;
         r_ip    <= '0;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_im    <= w_im_nx;
         r_ie    <= w_ie_nx;
         r_bd    <= w_bd_nx;
         r_exc   <= w_exc_nx;
         r_ip    <= bus.hw_int;
         r_epc   <= w_epc_nx;
      end
   end
   assign bus.rdata = (bus.addr == 5'd12) ? {16'h0, r_im, 8'h0, w_exl, r_ie} :
                      (bus.addr == 5'd13) ? {r_bd, 15'h0, r_ip, 3'b000, r_exc, 2'b00} :
                      (bus.addr == 5'd14) ? r_epc :
                      (bus.addr == 5'd15) ? PRID : 32'h0;
   assign bus.req        = w_req;
   assign bus.handler_pc = 32'h0000_4180;
   assign bus.epc_out    = w_epc_we ? {bus.wdata[31:2], 2'b00} : r_epc;
   assign bus.in_handler = w_exl;
endmodule

// File: doc/cp0_intr_unit.md
CP0_INTR_UNIT -- requirements
Module: cp0_intr_unit

Interface
REQ-001 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- hw_int  in  6  external interrupt lines, level, bit 0 = IRQ0
- exc_valid  in  1  pipeline reports an internal exception this cycle
- exc_code  in  5  ExcCode for that exception
- pc_in  in  32  PC of the victim instruction
- bd_in  in  1  victim instruction is in a delay slot
- we  in  1  mtc0 write strobe
- addr  in  5  CP0 register number for read and write
- wdata  in  32  mtc0 data
- eret  in  1  eret retires this cycle
- rdata  out  32  mfc0 data
- req  out  1  flush and redirect to the handler
- handler_pc  out  32  constant 32'h0000_4180
- epc_out  out  32  eret target
- in_handler  out  1  mirrors SR.EXL
REQ-002 The block SHALL have one parameter: PRID, default 32'h0000_2021, the read value of register 15.

Function
REQ-003 SR (reg 12) SHALL implement only IM[15:10], EXL[1] and IE[0]; all other bits SHALL read 0 and ignore writes.
REQ-004 Cause (reg 13) SHALL implement BD[31], IP[15:10] and ExcCode[6:2]; all other bits SHALL read 0; mtc0 to reg 13 SHALL be ignored.
REQ-005 EPC (reg 14) SHALL be 32 bits; bits [1:0] SHALL always be stored as 0.
REQ-006 PRId (reg 15) SHALL read PRID and ignore writes; any other addr SHALL read 32'h0.
REQ-007 rdata SHALL be combinational from addr and the current register state, with no write-through of same-cycle wdata.
REQ-008 Cause.IP SHALL be loaded from hw_int on every clock edge (one cycle latency), regardless of EXL or req.
REQ-009 int_req SHALL be asserted when |(hw_int & SR.IM) & SR.IE & ~SR.EXL; it is evaluated on the live hw_int, not on the registered IP.
REQ-010 exc_req SHALL be asserted when exc_valid & ~SR.EXL.
REQ-011 req SHALL equal int_req | exc_req, combinationally.
REQ-012 When both are active, the interrupt SHALL take priority: ExcCode is 0 and exc_code is discarded.
REQ-013 On a clock edge with req=1, the block SHALL perform all of the following:
- SR.EXL <= 1
- Cause.BD <= bd_in
- Cause.ExcCode <= int_req ? 0 : exc_code
- EPC <= (bd_in ? pc_in-4 : pc_in) with [1:0] cleared; the subtraction is 32-bit and wraps modulo 2^32
REQ-014 On an edge with req=1, any same-cycle mtc0 SHALL be discarded.
REQ-015 States: NORMAL (EXL=0) and HANDLER (EXL=1). Transitions:
- NORMAL -> HANDLER on req
- HANDLER -> NORMAL on eret
- mtc0 to SR may also set or clear EXL directly
REQ-016 eret in NORMAL SHALL be a no-op on all state.
REQ-017 eret SHALL take precedence over a same-cycle mtc0 write to the EXL bit; the write's IM and IE fields still apply.
REQ-018 epc_out SHALL be EPC, except when we=1 and addr=14 in the same cycle, when it SHALL be {wdata[31:2],2'b00}; this gives a same-cycle mtc0/eret forward.
REQ-019 While EXL=1, hw_int activity SHALL update IP only; no nested req is raised.
REQ-020 An interrupt masked at assertion SHALL raise req on the first cycle in which IM, IE and ~EXL all permit it while the line is still high.
REQ-021 If a line drops before it is unmasked, no request SHALL be raised; the unit does no pending latching.
REQ-022 in_handler SHALL equal SR.EXL.

Reset
REQ-023 On reset=1 at a clock edge, the block SHALL set SR, Cause and EPC to 32'h0, i.e. EXL=0, IE=0, IM=0, IP=0.
REQ-024 Reset SHALL override req, we and eret in the same cycle.
REQ-025 While reset=1, req SHALL still evaluate combinationally, but it SHALL be 0 because IE=0.
REQ-026 Reset asserted while in HANDLER SHALL return the block to NORMAL on that edge.

Verification
REQ-027 The bench SHALL cover these scenarios:
- mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 held 6 cycles, pc_in=32'h0000_3024, bd_in=0 -> req=1 in the first cycle only; next cycle EXL=1, EPC=32'h0000_3024, ExcCode=0, Cause reads 32'h0000_1000 while the line is high; after hw_int drops, IP=0 one edge later.
- EXL=0, exc_valid=1, exc_code=5'd4, pc_in=32'h0000_3100, bd_in=1 -> EPC=32'h0000_30FC, Cause[31]=1, ExcCode=4.
- Same cycle hw_int[0]=1 (unmasked) and exc_valid with code 10 -> ExcCode=0.
- HANDLER, eret with we=1, addr=14, wdata=32'h0000_3203 -> epc_out=32'h0000_3200 that cycle; EXL=0 next edge.
- SR=32'h0000_0401, hw_int[1]=1 -> no req; mtc0 SR=32'h0000_0801 while the line is still high -> req the cycle after the write takes effect.
- Reset during HANDLER with hw_int=6'h3F -> all registers 0 next edge, req=0, rdata(15)=32'h0000_2021.
